// File: rtl/dmem_pkg.sv
// Shared types and helpers for the dmem_lsu data memory.
// Build option: DMEM_MISALIGN_TRAP_EN selects trapping rather than silently aligning misaligned accesses.
package dmem_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    SZ_B  = 3'b000,
    SZ_H  = 3'b001,
    SZ_W  = 3'b010,
    SZ_BU = 3'b100,
    SZ_HU = 3'b101
  } mem_size_e;

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } mem_state_e;

  function automatic logic size_legal(input logic [2:0] size);
    case (size)
      SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

  // Low funct3 bits encode the access width (00 byte, 01 half, 10 word).
  function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] off);
    case (size[1:0])
      2'b01:   return off[0];
      2'b10:   return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] align_off(input logic [2:0] size, input logic [1:0] off);
    case (size[1:0])
      2'b01:   return {off[1], 1'b0};
      2'b10:   return 2'b00;
      default: return off;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// Byte-lane formatting: store mask/replicated data and load select/extend.
// Purely combinational; offsets arrive already aligned for the access size.
module dmem_lane_fmt
  import dmem_pkg::*;
(
  input  logic [2:0]      st_size,
  input  logic [1:0]      st_off,
  input  logic [XLEN-1:0] st_wdata,
  output logic [3:0]      st_mask,
  output logic [XLEN-1:0] st_lane_data,
  input  logic [2:0]      ld_size,
  input  logic [1:0]      ld_off,
  input  logic [XLEN-1:0] ld_raw,
  output logic [XLEN-1:0] ld_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    st_mask      = 4'b0000;
    st_lane_data = st_wdata;
    case (st_size)
      SZ_B: begin
        st_mask      = 4'b0001 << st_off;
        st_lane_data = {4{st_wdata[7:0]}};
      end
      SZ_H: begin
        st_mask      = st_off[1] ? 4'b1100 : 4'b0011;
        st_lane_data = {2{st_wdata[15:0]}};
      end
      SZ_W: begin
        st_mask      = 4'b1111;
        st_lane_data = st_wdata;
      end
      default: begin
        st_mask      = 4'b0000;
        st_lane_data = st_wdata;
      end
    endcase
  end

  always_comb begin
    byte_sel = ld_raw[{ld_off, 3'b000} +: 8];
    half_sel = ld_off[1] ? ld_raw[31:16] : ld_raw[15:0];
    case (ld_size)
      SZ_B:    ld_data = {{24{byte_sel[7]}}, byte_sel};
      SZ_BU:   ld_data = {24'h000000, byte_sel};
      SZ_H:    ld_data = {{16{half_sel[15]}}, half_sel};
      SZ_HU:   ld_data = {16'h0000, half_sel};
      SZ_W:    ld_data = ld_raw;
      default: ld_data = '0;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// RV32 data memory for the MEM stage: valid/ready request and response, one response slot.
// Build option: DMEM_MISALIGN_TRAP_EN flags misaligned H/W accesses instead of aligning them.
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        init_done
);

  localparam int          AW   = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);

  logic [31:0] mem [DEPTH_WORDS];

  mem_state_e  state_reg;
  logic [AW-1:0] clr_idx_reg;
  logic        init_done_reg;
  logic        rsp_valid_reg;
  logic        rsp_err_reg;
  logic        rsp_load_reg;
  logic [2:0]  rsp_size_reg;
  logic [1:0]  rsp_off_reg;
  logic [31:0] raw_reg;

  logic [31:0]   offset;
  logic [AW-1:0] req_idx;
  logic          in_range;
  logic          align_err;
  logic [1:0]    eff_off;
  logic          req_err;
  logic          accept;

  logic [3:0]    st_mask;
  logic [31:0]   st_lane_data;
  logic [31:0]   ld_data;

  logic [3:0]    mem_we;
  logic [AW-1:0] mem_waddr;
  logic [31:0]   mem_wdata;

  // Unsigned subtraction makes addresses below BASE_ADDR wrap high and fail the range test.
  assign offset   = req_addr - BASE_ADDR;
  assign in_range = offset < SPAN;
  assign req_idx  = offset[AW+1:2];

`ifdef DMEM_MISALIGN_TRAP_EN
  assign eff_off   = req_addr[1:0];
  assign align_err = is_misaligned(req_size, req_addr[1:0]);
`else
  assign eff_off   = align_off(req_size, req_addr[1:0]);
  assign align_err = 1'b0;
`endif

  assign req_err   = !in_range || !size_legal(req_size) || align_err;
  assign req_ready = (state_reg == ST_READY) && (!rsp_valid_reg || rsp_ready);
  assign accept    = req_valid && req_ready;

  dmem_lane_fmt u_fmt (
    .st_size      (req_size),
    .st_off       (eff_off),
    .st_wdata     (req_wdata),
    .st_mask      (st_mask),
    .st_lane_data (st_lane_data),
    .ld_size      (rsp_size_reg),
    .ld_off       (rsp_off_reg),
    .ld_raw       (raw_reg),
    .ld_data      (ld_data)
  );

  always_comb begin
    mem_we    = 4'b0000;
    mem_waddr = req_idx;
    mem_wdata = st_lane_data;
    if (state_reg == ST_CLEAR) begin
      mem_we    = 4'b1111;
      mem_waddr = clr_idx_reg;
      mem_wdata = '0;
    end else if (accept && req_we && !req_err) begin
      mem_we = st_mask;
    end
  end

  // Array port: byte-masked write plus registered read; contents are cleared by the sweep, not by reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (mem_we[b]) mem[mem_waddr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    if (accept) raw_reg <= mem[req_idx];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= ST_CLEAR;
      clr_idx_reg   <= '0;
      init_done_reg <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      rsp_load_reg  <= 1'b0;
      rsp_size_reg  <= 3'b000;
      rsp_off_reg   <= 2'b00;
    end else begin
      case (state_reg)
        ST_CLEAR: begin
          if (clr_idx_reg == AW'(DEPTH_WORDS - 1)) begin
            state_reg     <= ST_READY;
            init_done_reg <= 1'b1;
          end else begin
            clr_idx_reg <= clr_idx_reg + 1'b1;
          end
        end
        ST_READY: begin
          if (accept) begin
            rsp_valid_reg <= 1'b1;
            rsp_err_reg   <= req_err;
            rsp_load_reg  <= !req_we && !req_err;
            rsp_size_reg  <= req_size;
            rsp_off_reg   <= eff_off;
          end else if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
          end
        end
        default: state_reg <= ST_CLEAR;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_reg;
  assign rsp_err   = rsp_err_reg;
  assign rsp_rdata = rsp_load_reg ? ld_data : 32'h0000_0000;
  assign init_done = init_done_reg;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed, table-driven bench for dmem_lsu with a 16-word array at address 0.
// Expectations for misaligned accesses follow whether DMEM_MISALIGN_TRAP_EN is defined.
module tb_dmem_lsu;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [2:0]  req_size;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        init_done;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  dmem_lsu #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_size  (req_size),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .init_done (init_done)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) begin
      passed++;
      $display("ok   %-22s got %h", name, act);
    end else begin
      $display("FAIL %-22s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic we, input logic [31:0] addr, input logic [2:0] size,
                     input logic [31:0] wdata, input logic [31:0] rd, input logic err,
                     input string name);
    vec_t v;
    v.we = we; v.addr = addr; v.size = size; v.wdata = wdata;
    v.exp_rdata = rd; v.exp_err = err; v.name = name;
    vecs.push_back(v);
  endtask

  // Called at posedge+1; returns response sampled one cycle after acceptance.
  task automatic xfer(input logic we, input logic [31:0] addr, input logic [2:0] size,
                      input logic [31:0] wdata, output logic [31:0] rdata,
                      output logic err, output logic valid);
    int n;
    n = 0;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size; req_wdata = wdata;
    while (!req_ready && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) begin
      check("req_ready_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      rdata = 'x; err = 1'bx; valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      rdata = rsp_rdata; err = rsp_err; valid = rsp_valid;
    end
  endtask

  task automatic wait_init(output int cycles);
    cycles = 0;
    while (!init_done && cycles < 100) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    logic        vl;
    logic [31:0] hold_rd;
    logic        hold_er;
    int          cyc;

    reset_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_size = 3'b010; req_wdata = '0; rsp_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);

    // Release and hold a store request throughout the clear sweep; it must not be accepted.
    @(negedge clk);
    reset_n = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0; req_size = 3'b010; req_wdata = 32'hFFFF_FFFF;
    for (int i = 1; i <= DEPTH; i++) begin
      @(posedge clk); #1;
      if (i < DEPTH) begin
        check($sformatf("clr%0d_init_done", i), 32'(init_done), 32'd0);
        check($sformatf("clr%0d_req_ready", i), 32'(req_ready), 32'd0);
        check($sformatf("clr%0d_rsp_valid", i), 32'(rsp_valid), 32'd0);
      end else begin
        check("clr_init_done_rise", 32'(init_done), 32'd1);
      end
    end
    req_valid = 1'b0;

    add(1'b0, 32'h00, 3'b010, 32'h0,         32'h0000_0000, 1'b0, "LW 00 after clear");
    add(1'b1, 32'h04, 3'b010, 32'hA5A5_A5A5, 32'h0000_0000, 1'b0, "SW 04");
    add(1'b1, 32'h05, 3'b000, 32'h0000_003C, 32'h0000_0000, 1'b0, "SB 05");
    add(1'b0, 32'h04, 3'b010, 32'h0,         32'hA5A5_3CA5, 1'b0, "LW 04");
    add(1'b0, 32'h05, 3'b000, 32'h0,         32'h0000_003C, 1'b0, "LB 05");
    add(1'b0, 32'h07, 3'b100, 32'h0,         32'h0000_00A5, 1'b0, "LBU 07");
    add(1'b0, 32'h07, 3'b000, 32'h0,         32'hFFFF_FFA5, 1'b0, "LB 07");
    add(1'b0, 32'h04, 3'b000, 32'h0,         32'hFFFF_FFA5, 1'b0, "LB 04");
    add(1'b0, 32'h04, 3'b001, 32'h0,         32'h0000_3CA5, 1'b0, "LH 04");
    add(1'b0, 32'h06, 3'b101, 32'h0,         32'h0000_A5A5, 1'b0, "LHU 06");
    add(1'b1, 32'h12, 3'b001, 32'h0000_8001, 32'h0000_0000, 1'b0, "SH 12");
    add(1'b0, 32'h10, 3'b010, 32'h0,         32'h8001_0000, 1'b0, "LW 10");
    add(1'b0, 32'h12, 3'b001, 32'h0,         32'hFFFF_8001, 1'b0, "LH 12");
    add(1'b0, 32'h12, 3'b101, 32'h0,         32'h0000_8001, 1'b0, "LHU 12");
    add(1'b0, 32'h10, 3'b001, 32'h0,         32'h0000_0000, 1'b0, "LH 10");
    add(1'b1, 32'h40, 3'b010, 32'h1234_5678, 32'h0000_0000, 1'b1, "SW 40 out of range");
    add(1'b0, 32'h00, 3'b010, 32'h0,         32'h0000_0000, 1'b0, "LW 00 unchanged");
    add(1'b0, 32'hFFFF_FFFC, 3'b010, 32'h0,  32'h0000_0000, 1'b1, "LW FFFFFFFC range");
    add(1'b0, 32'h04, 3'b011, 32'h0,         32'h0000_0000, 1'b1, "load size 011");
    add(1'b1, 32'h04, 3'b011, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, "store size 011");
    add(1'b0, 32'h04, 3'b111, 32'h0,         32'h0000_0000, 1'b1, "load size 111");
    add(1'b0, 32'h04, 3'b010, 32'h0,         32'hA5A5_3CA5, 1'b0, "LW 04 unchanged");
`ifdef DMEM_MISALIGN_TRAP_EN
    add(1'b1, 32'h02, 3'b010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1, "SW 02 misaligned");
    add(1'b0, 32'h00, 3'b010, 32'h0,         32'h0000_0000, 1'b0, "LW 00 after SW 02");
    add(1'b0, 32'h13, 3'b101, 32'h0,         32'h0000_0000, 1'b1, "LHU 13 misaligned");
    add(1'b0, 32'h13, 3'b010, 32'h0,         32'h0000_0000, 1'b1, "LW 13 misaligned");
`else
    add(1'b1, 32'h02, 3'b010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, "SW 02 aligned down");
    add(1'b0, 32'h00, 3'b010, 32'h0,         32'hDEAD_BEEF, 1'b0, "LW 00 after SW 02");
    add(1'b0, 32'h13, 3'b101, 32'h0,         32'h0000_8001, 1'b0, "LHU 13 aligned down");
    add(1'b0, 32'h13, 3'b010, 32'h0,         32'h8001_0000, 1'b0, "LW 13 aligned down");
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      xfer(vecs[i].we, vecs[i].addr, vecs[i].size, vecs[i].wdata, rd, er, vl);
      check({vecs[i].name, " valid"}, 32'(vl), 32'd1);
      check({vecs[i].name, " rdata"}, rd, vecs[i].exp_rdata);
      check({vecs[i].name, " err"}, 32'(er), 32'(vecs[i].exp_err));
    end

    // Back-pressure: response held for 3 cycles while a second load waits.
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    xfer(1'b0, 32'h04, 3'b010, 32'h0, rd, er, vl);
    check("stall first valid", 32'(vl), 32'd1);
    check("stall first rdata", rd, 32'hA5A5_3CA5);
    hold_rd = rsp_rdata; hold_er = rsp_err;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_size = 3'b010;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("stall%0d valid", i), 32'(rsp_valid), 32'd1);
      check($sformatf("stall%0d rdata", i), rsp_rdata, hold_rd);
      check($sformatf("stall%0d err", i), 32'(rsp_err), 32'(hold_er));
      check($sformatf("stall%0d req_ready", i), 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    #1;
    check("unstall req_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    check("unstall second valid", 32'(rsp_valid), 32'd1);
    check("unstall second rdata", rsp_rdata, 32'h8001_0000);

    // Streaming LW/SW/LW to the same word, one per cycle.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_size = 3'b010;
    check("stream0 req_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    check("stream0 valid", 32'(rsp_valid), 32'd1);
    check("stream0 rdata", rsp_rdata, 32'h8001_0000);
    req_we = 1'b1; req_wdata = 32'h1122_3344;
    check("stream1 req_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    check("stream1 valid", 32'(rsp_valid), 32'd1);
    check("stream1 rdata", rsp_rdata, 32'h0);
    check("stream1 err", 32'(rsp_err), 32'd0);
    req_we = 1'b0;
    check("stream2 req_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    check("stream2 valid", 32'(rsp_valid), 32'd1);
    check("stream2 rdata", rsp_rdata, 32'h1122_3344);
    req_valid = 1'b0;

    // Reset while a response is pending.
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    xfer(1'b0, 32'h04, 3'b010, 32'h0, rd, er, vl);
    check("pre-reset valid", 32'(vl), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid-reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid-reset init_done", 32'(init_done), 32'd0);
    check("mid-reset req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    rsp_ready = 1'b1;
    wait_init(cyc);
    check("re-clear cycles", 32'(cyc), 32'(DEPTH));
    xfer(1'b0, 32'h04, 3'b010, 32'h0, rd, er, vl);
    check("post-reset LW 04 valid", 32'(vl), 32'd1);
    check("post-reset LW 04 rdata", rd, 32'h0);
    xfer(1'b0, 32'h10, 3'b010, 32'h0, rd, er, vl);
    check("post-reset LW 10 rdata", rd, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
